// File: rtl/sr_trace_buf_if.sv
// Trace-buffer bus: commit capture from the CPU retire point and the valid/ready drain port.
interface sr_trace_buf_if #(
    parameter int CYC_W = 16
) ();
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic [31:0]      commit_instr;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_wdata;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [4:0]       out_rd;
    logic [31:0]      out_wdata;
    logic [CYC_W-1:0] out_cycle;
    logic             out_gap;

    // Master is the CPU/consumer side, slave is the trace buffer.
    modport master (
        output commit_valid, commit_pc, commit_instr, commit_rd, commit_wdata, out_ready,
        input  out_valid, out_pc, out_instr, out_rd, out_wdata, out_cycle, out_gap
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_rd, commit_wdata, out_ready,
        output out_valid, out_pc, out_instr, out_rd, out_wdata, out_cycle, out_gap
    );
endinterface

// File: rtl/sr_trace_buf.sv
// Commit-trace buffer: stamps retired-instruction records into a first-word-fall-through FIFO;
// overflow never stalls the CPU, it drops the record, counts it and flags the gap on the next one.
module sr_trace_buf #(
    parameter int DEPTH = 16,
    parameter int CYC_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trc_en,
    sr_trace_buf_if.slave          trc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic [15:0]            drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [4:0]       rd;
        logic [31:0]      wdata;
        logic [CYC_W-1:0] cycle;
        logic             gap;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             head;
    rec_t             newRec;
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CYC_W-1:0] cyc;
    logic             pendingGap;
    logic             pushReq;
    logic             push;
    logic             pop;
    logic             drop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = trc.out_valid & trc.out_ready;
    assign pushReq = trc.commit_valid & trc_en;
    // A full buffer still accepts a record when the head leaves on the same edge.
    assign push    = pushReq & (~full | pop);
    assign drop    = pushReq & full & ~pop;

    assign newRec  = {trc.commit_pc, trc.commit_instr, trc.commit_rd, trc.commit_wdata, cyc, pendingGap};

    // NOTE: every register here uses <= so all updates see the pre-edge values of their neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            cyc        <= '0;
            drop_cnt   <= '0;
            pendingGap <= 1'b0;
        end else begin
            cyc <= cyc + CYC_W'(1);
            if (push) begin
                wrPtr      <= wrPtr + AW'(1);
                pendingGap <= 1'b0;
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            if (drop) begin
                pendingGap <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wrPtr] <= newRec;
        end
    end

    assign head          = mem[rdPtr];
    assign trc.out_valid = (count != '0);
    assign trc.out_pc    = head.pc;
    assign trc.out_instr = head.instr;
    assign trc.out_rd    = head.rd;
    assign trc.out_wdata = head.wdata;
    assign trc.out_cycle = head.cycle;
    assign trc.out_gap   = head.gap;
endmodule
